// File: rtl/lc3_ctrl_pkg.sv
// Shared LC-3 control types: fetch FSM state encoding and PCMUX select codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lc3_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_FETCH_ADDR    = 3'd1,
        S_FETCH_WAIT    = 3'd2,
        S_FETCH_LOAD_IR = 3'd3,
        S_ISSUE         = 3'd4
    } fetch_state_t;

    // PCMUX select codes, shared with the PC next-value mux.
    localparam logic [1:0] PCMUX_INC  = 2'b00;
    localparam logic [1:0] PCMUX_ADDR = 2'b01;
    localparam logic [1:0] PCMUX_BUS  = 2'b10;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: PC path, instruction-memory read handshake, decode IR handshake.
// master = fetch unit (drives LD_PC/PCMUX_sig/mem_*/IR/MAR/MDR/ir_valid/bus_err/fetch_count).
// slave  = surroundings (drive run/flush/PC_out/mem_rdata/mem_ready/ir_ready).
interface instr_fetch_unit_if #(
    parameter int WIDTH = 16
);
    logic             run;
    logic             flush;
    logic [WIDTH-1:0] PC_out;
    logic             LD_PC;
    logic [1:0]       PCMUX_sig;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_rd;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;
    logic [WIDTH-1:0] IR;
    logic [WIDTH-1:0] MAR;
    logic [WIDTH-1:0] MDR;
    logic             ir_valid;
    logic             ir_ready;
    logic             bus_err;
    logic [15:0]      fetch_count;

    modport master (
        input  run, flush, PC_out, mem_rdata, mem_ready, ir_ready,
        output LD_PC, PCMUX_sig, mem_addr, mem_rd, IR, MAR, MDR,
               ir_valid, bus_err, fetch_count
    );

    modport slave (
        output run, flush, PC_out, mem_rdata, mem_ready, ir_ready,
        input  LD_PC, PCMUX_sig, mem_addr, mem_rd, IR, MAR, MDR,
               ir_valid, bus_err, fetch_count
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// LC-3 instruction fetch: MAR<-PC, PC<-PC+1, MDR<-M[MAR], IR<-MDR, then hand IR to decode.
// Latency: run seen in IDLE -> ir_valid 4 cycles later (zero-wait memory); 1 instr / 4 cycles.
// Backpressure: holds IR/ir_valid in ISSUE until ir_ready; memory stalls bounded by TIMEOUT.
// Ports: Clk, Reset_n (async active-low), bus (instr_fetch_unit_if.master).
module instr_fetch_unit
    import lc3_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int WIDTH   = 16
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    instr_fetch_unit_if.master    bus
);

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    fetch_state_t     state_q;
    logic [WIDTH-1:0] mar_q;
    logic [WIDTH-1:0] mdr_q;
    logic [WIDTH-1:0] ir_q;
    logic [15:0]      fetch_count_q;
    logic [15:0]      fetch_count_d;
    logic [7:0]       wait_q;
    logic [7:0]       wait_d;
    logic             ld_pc_q;
    logic [1:0]       pcmux_q;
    logic             mem_rd_q;
    logic             ir_valid_q;
    logic             bus_err_q;

    assign fetch_count_d = fetch_count_q + 16'd1;   // wraps FFFF -> 0
    assign wait_d        = wait_q + 8'd1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= S_IDLE;
            mar_q         <= '0;
            mdr_q         <= '0;
            ir_q          <= '0;
            fetch_count_q <= '0;
            wait_q        <= '0;
            ld_pc_q       <= 1'b0;
            pcmux_q       <= PCMUX_INC;
            mem_rd_q      <= 1'b0;
            ir_valid_q    <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            // LD_PC is a one-cycle pulse, only ever raised on entry to FETCH_ADDR.
            ld_pc_q <= 1'b0;
            pcmux_q <= PCMUX_INC;
            case (state_q)
                S_IDLE: begin
                    if (bus.run && !bus_err_q) begin
                        state_q <= S_FETCH_ADDR;
                        ld_pc_q <= 1'b1;
                    end
                end
                S_FETCH_ADDR: begin
                    // PC has already been told to increment this cycle; a flush
                    // does not undo that, the redirect owner reloads PC.
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        mar_q    <= bus.PC_out;
                        wait_q   <= '0;
                        mem_rd_q <= 1'b1;
                        state_q  <= S_FETCH_WAIT;
                    end
                end
                S_FETCH_WAIT: begin
                    if (bus.flush) begin
                        mem_rd_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end else if (bus.mem_ready) begin
                        mdr_q    <= bus.mem_rdata;
                        mem_rd_q <= 1'b0;
                        state_q  <= S_FETCH_LOAD_IR;
                    end else if (wait_d == TIMEOUT_W) begin
                        bus_err_q <= 1'b1;
                        mem_rd_q  <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                S_FETCH_LOAD_IR: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        ir_q       <= mdr_q;
                        ir_valid_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // flush wins over ir_ready: the instruction is dropped uncounted.
                    if (bus.flush) begin
                        ir_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (bus.ir_ready) begin
                        fetch_count_q <= fetch_count_d;
                        ir_valid_q    <= 1'b0;
                        if (bus.run) begin
                            ld_pc_q <= 1'b1;
                            state_q <= S_FETCH_ADDR;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.LD_PC       = ld_pc_q;
    assign bus.PCMUX_sig   = pcmux_q;
    assign bus.mem_addr    = mar_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.IR          = ir_q;
    assign bus.MAR         = mar_q;
    assign bus.MDR         = mdr_q;
    assign bus.ir_valid    = ir_valid_q;
    assign bus.bus_err     = bus_err_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequences the LC-3 instruction fetch: MAR <- PC, PC <- PC+1, MDR <- M[MAR], IR <- MDR.
- Consumes the PC register's Q output, reads instruction memory through a ready/strobe handshake, and presents the fetched IR to decode with a valid/ready handshake.
- Drives LD_PC and the PCMUX select (increment encoding) during fetch, the reading end of the PC path.
- Sits in the datapath/control boundary between the PC register, memory interface and the decode FSM.

Parameters:
- TIMEOUT, 15, max FETCH_WAIT cycles without mem_ready before a bus error (1..255).
- WIDTH, 16, datapath width for PC/MAR/MDR/IR.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; fetch continuously while high.
- flush  in  1  pulse; abandon current fetch (branch/redirect).
- PC_out  in  WIDTH  current PC register Q.
- LD_PC  out  1  PC register load enable.
- PCMUX_sig  out  2  PCMUX select; 2'b00 (increment) whenever LD_PC=1, else 2'b00.
- mem_addr  out  WIDTH  memory address (=MAR).
- mem_rd  out  1  memory read strobe.
- mem_rdata  in  WIDTH  memory read data.
- mem_ready  in  1  read data valid this cycle.
- IR  out  WIDTH  instruction register.
- MAR  out  WIDTH  memory address register.
- MDR  out  WIDTH  memory data register.
- ir_valid  out  1  IR holds a fresh instruction.
- ir_ready  in  1  decode accepts IR.
- bus_err  out  1  sticky timeout flag.
- fetch_count  out  16  count of accepted instructions.

Behaviour:
- Reset: state IDLE; IR, MAR, MDR, fetch_count = 0; LD_PC, mem_rd, ir_valid, bus_err = 0; PCMUX_sig = 2'b00. Reset mid-fetch aborts immediately; no memory strobe after reset assertion.
- States: IDLE, FETCH_ADDR, FETCH_WAIT, FETCH_LOAD_IR, ISSUE.
- IDLE: if run && !bus_err -> FETCH_ADDR.
- FETCH_ADDR: MAR <= PC_out; LD_PC=1, PCMUX_sig=00 (PC <= PC+1 at the same edge); wait counter cleared -> FETCH_WAIT.
- FETCH_WAIT: mem_rd=1, mem_addr=MAR. On mem_ready: MDR <= mem_rdata -> FETCH_LOAD_IR. Else increment counter; when counter reaches TIMEOUT without mem_ready: bus_err <= 1 -> IDLE.
- FETCH_LOAD_IR: IR <= MDR -> ISSUE.
- ISSUE: ir_valid=1; IR stable. On ir_ready: fetch_count += 1 (wraps 16'hFFFF -> 0); -> FETCH_ADDR if run else IDLE.
- Latency: run seen in IDLE -> ir_valid high 4 cycles later with zero-wait memory. Back-to-back throughput is 1 instruction / 4 cycles.
- flush (any non-IDLE state) -> IDLE next cycle; ir_valid drops; pending read abandoned, late mem_ready ignored; MDR/IR not updated. flush beats ir_ready in the same cycle: instruction discarded, fetch_count unchanged. PC already incremented is not rolled back (redirect owner reloads PC).
- bus_err clears only on reset; blocks IDLE exit.
- Width: all registers WIDTH bits; no sign handling.

Decomposition:
- Package lc3_ctrl_pkg: fetch_state_t enum; PCMUX_INC=2'b00, PCMUX_ADDR=2'b01, PCMUX_BUS=2'b10 constants shared with the PC next-value logic.
- No sub-module. FSM, wait counter and registers stay in one module.

Test Plan:
- Reset_n low, run=1, PC_out=16'h3000, mem_ready immediate, mem_rdata=16'h1261 -> cycle after run: LD_PC=1, MAR=3000; 4 cycles later ir_valid=1, IR=1261; ir_ready=1 -> fetch_count=1.
- mem_ready delayed 3 cycles -> mem_rd high exactly 4 cycles at mem_addr=MAR; ir_valid 3 cycles later than baseline.
- mem_ready never asserted, TIMEOUT=15 -> bus_err=1 after 15 FETCH_WAIT cycles, state IDLE, no further LD_PC despite run=1.
- flush in FETCH_WAIT, then mem_ready with 16'hBEEF -> MDR/IR unchanged, ir_valid stays 0; flush and ir_ready same cycle in ISSUE -> fetch_count unchanged.
- ir_ready held low 10 cycles in ISSUE -> IR and ir_valid stable, no LD_PC/mem_rd; fetch_count preset 16'hFFFF wraps to 0 on accept.
- Reset_n asserted asynchronously mid-FETCH_WAIT -> all outputs at reset values before next Clk edge.
